// File: rtl/top.sv
// top: dual-lane 64-bit rotate/align registers with folded XOR checksum, capture counter and leading-zero count.
module top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [136:0] in_flat,
  output logic [158:0] out_flat
);
  logic [63:0] w_da, w_db, w_rota, w_rotb, w_x;
  logic [5:0]  w_sh;
  logic [6:0]  w_shc, w_lzc;
  logic        w_va, w_vb, w_clr;
  logic [15:0] w_f;
  logic [63:0] r_a, r_b;
  logic [15:0] r_chk;
  logic [7:0]  r_cnt;
  assign w_da  = in_flat[63:0];
  assign w_db  = in_flat[127:64];
  assign w_sh  = in_flat[133:128];
  assign w_va  = in_flat[134];
  assign w_vb  = in_flat[135];
  assign w_clr = in_flat[136];
  // A 64-bit shift yields zero, so sh=0 leaves the data unchanged.
  assign w_shc  = 7'd64 - {1'b0, w_sh};
  assign w_rota = (w_da << w_sh) | (w_da >> w_shc);
  assign w_rotb = (w_db >> w_sh) | (w_db << w_shc);
  assign w_x    = w_rota ^ w_rotb;
  assign w_f    = w_x[15:0] ^ w_x[31:16] ^ w_x[47:32] ^ w_x[63:48];
  always_comb begin
    w_lzc = 7'd64;
    for (int i = 0; i < 64; i++)
      if (r_a[i]) w_lzc = 7'(63 - i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_chk <= '0;
      r_cnt <= '0;
    end else if (w_clr) begin
      r_a   <= '0;
      r_b   <= '0;
      r_chk <= '0;
      r_cnt <= '0;
    end else begin
      if (w_va) r_a <= w_rota;
      if (w_vb) r_b <= w_rotb;
      if (w_va && w_vb) begin
        r_chk <= r_chk + w_f;
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
  assign out_flat = {w_lzc, r_cnt, r_chk, r_b, r_a};
endmodule

// File: tb/tb_top.sv
// tb_top: randomized self-checking bench for top against a bit-level behavioural model.
module tb_top;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [136:0] in_flat;
  logic [158:0] out_flat;
  int tests = 0;
  int fails = 0;
  logic [63:0] m_a, m_b;
  logic [15:0] m_chk;
  int          m_cnt;
  top dut (.clk(clk), .rst_n(rst_n), .in_flat(in_flat), .out_flat(out_flat));
  always #5 clk = ~clk;
  function automatic logic [63:0] rotl(input logic [63:0] d, input int s);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[(i + s) % 64] = d[i];
    return r;
  endfunction
  function automatic logic [63:0] rotr(input logic [63:0] d, input int s);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = d[(i + s) % 64];
    return r;
  endfunction
  function automatic int lz(input logic [63:0] d);
    int n = 0;
    bit done = 0;
    for (int i = 63; i >= 0; i--) begin
      if (d[i]) done = 1;
      if (!done) n++;
    end
    return n;
  endfunction
  function automatic logic [15:0] fold(input logic [63:0] x);
    logic [15:0] f = '0;
    for (int w = 0; w < 4; w++) f ^= x[16*w +: 16];
    return f;
  endfunction
  function automatic logic [158:0] ref_out();
    logic [6:0] l = 7'(lz(m_a));
    logic [7:0] c = 8'(m_cnt % 256);
    return {l, c, m_chk, m_b, m_a};
  endfunction
  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction
  task automatic model_clear();
    m_a = '0; m_b = '0; m_chk = '0; m_cnt = 0;
  endtask
  task automatic drive(input logic [63:0] da, input logic [63:0] db, input int sh,
                       input bit va, input bit vb, input bit clr);
    @(negedge clk);
    in_flat = {clr, vb, va, 6'(sh), db, da};
  endtask
  task automatic tick();
    logic [63:0] da, db;
    int sh;
    @(posedge clk);
    da = in_flat[63:0];
    db = in_flat[127:64];
    sh = int'(in_flat[133:128]);
    if (!rst_n || in_flat[136]) model_clear();
    else begin
      if (in_flat[134] && in_flat[135]) begin
        m_chk = m_chk + fold(rotl(da, sh) ^ rotr(db, sh));
        m_cnt = (m_cnt + 1) % 256;
      end
      if (in_flat[134]) m_a = rotl(da, sh);
      if (in_flat[135]) m_b = rotr(db, sh);
    end
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    in_flat = {$urandom, rnd64(), rnd64()};
    model_clear();
    #3;
    tests++;
    if (out_flat !== {7'h40, 152'd0}) begin
      fails++;
      $display("FAIL reset: got %h want %h", out_flat, {7'h40, 152'd0});
    end
    @(negedge clk);
    in_flat = '0;
    rst_n = 1'b1;
  endtask
  task automatic test_lane_a();
    logic [158:0] prev = out_flat;
    drive(64'h1, rnd64(), 4, 1, 0, 0);
    tick();
    tests++;
    if (out_flat[63:0] !== 64'h10 || out_flat[158:152] !== 7'd59 || out_flat[151:64] !== prev[151:64]) begin
      fails++;
      $display("FAIL lane_a: got %h prev %h want align_a=10 lzc=59", out_flat, prev);
    end
    tests++;
    if (out_flat !== ref_out()) begin
      fails++;
      $display("FAIL lane_a_model: got %h want %h", out_flat, ref_out());
    end
  endtask
  task automatic test_lane_b();
    logic [158:0] prev = out_flat;
    drive(rnd64(), 64'h1, 1, 0, 1, 0);
    tick();
    tests++;
    if (out_flat[127:64] !== 64'h8000000000000000 || out_flat[63:0] !== prev[63:0]
        || out_flat[151:128] !== prev[151:128]) begin
      fails++;
      $display("FAIL lane_b: got %h prev %h", out_flat, prev);
    end
  endtask
  task automatic test_checksum();
    rst_n = 1'b0;
    model_clear();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    drive(64'hFFFF, 64'h0, 0, 1, 1, 0);
    tick();
    tests++;
    if (out_flat[143:128] !== 16'hFFFF || out_flat[151:144] !== 8'd1) begin
      fails++;
      $display("FAIL checksum_1: got chk=%h cnt=%0d want chk=ffff cnt=1", out_flat[143:128], out_flat[151:144]);
    end
    drive(64'hFFFF, 64'h0, 0, 1, 1, 0);
    tick();
    tests++;
    if (out_flat[143:128] !== 16'hFFFE || out_flat[151:144] !== 8'd2) begin
      fails++;
      $display("FAIL checksum_2: got chk=%h cnt=%0d want chk=fffe cnt=2", out_flat[143:128], out_flat[151:144]);
    end
  endtask
  task automatic test_cancel();
    logic [158:0] prev = out_flat;
    drive(64'h1, 64'h1, 0, 1, 1, 0);
    tick();
    tests++;
    if (out_flat[143:128] !== prev[143:128] || out_flat[151:144] !== prev[151:144] + 8'd1
        || out_flat[63:0] !== 64'h1 || out_flat[127:64] !== 64'h1 || out_flat[158:152] !== 7'd63) begin
      fails++;
      $display("FAIL cancel: got %h prev %h", out_flat, prev);
    end
  endtask
  task automatic test_clear_wrap();
    drive(rnd64(), rnd64(), $urandom_range(0, 63), 1, 1, 0);
    tick();
    drive(rnd64(), rnd64(), $urandom_range(0, 63), 1, 1, 1);
    tick();
    tests++;
    if (out_flat !== {7'h40, 152'd0}) begin
      fails++;
      $display("FAIL clear: got %h want %h", out_flat, {7'h40, 152'd0});
    end
    for (int i = 0; i < 256; i++) begin
      drive(rnd64(), rnd64(), $urandom_range(0, 63), 1, 1, 0);
      tick();
    end
    tests++;
    if (out_flat[151:144] !== 8'd0) begin
      fails++;
      $display("FAIL cnt_wrap: got cnt=%0d want 0", out_flat[151:144]);
    end
    tests++;
    if (out_flat !== ref_out()) begin
      fails++;
      $display("FAIL wrap_model: got %h want %h", out_flat, ref_out());
    end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) begin
      drive(rnd64(), rnd64(), $urandom_range(0, 63), 1'($urandom), 1'($urandom), 0);
      tick();
    end
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    tests++;
    if (out_flat !== {7'h40, 152'd0}) begin
      fails++;
      $display("FAIL async_reset: got %h want %h", out_flat, {7'h40, 152'd0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_first_capture();
    drive(64'h8000000000000000, 64'h0, 0, 1, 0, 0);
    tick();
    tests++;
    if (out_flat[63:0] !== 64'h8000000000000000 || out_flat[158:152] !== 7'd0) begin
      fails++;
      $display("FAIL first_capture: got %h", out_flat);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      drive(rnd64(), rnd64(), $urandom_range(0, 63), 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
      tick();
      tests++;
      if (out_flat !== ref_out()) begin
        fails++;
        $display("FAIL random[%0d]: got %h want %h", i, out_flat, ref_out());
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    in_flat = '0;
    model_clear();
    test_reset();
    test_lane_a();
    test_lane_b();
    test_checksum();
    test_cancel();
    test_clear_wrap();
    test_async_reset();
    test_first_capture();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port in_flat, input, 137 bits, packed as follows:
- [63:0] data_a
- [127:64] data_b
- [133:128] sh, the alignment amount, 0..63
- [134] valid_a
- [135] valid_b
- [136] clr
REQ-004 The block SHALL have port out_flat, output, 159 bits, packed as follows:
- [63:0] align_a
- [127:64] align_b
- [143:128] chk
- [151:144] cnt
- [158:152] lzc
REQ-005 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-006 out_flat[151:0] SHALL come directly from registers, with no combinational path from in_flat.
REQ-007 lzc SHALL be combinational from the align_a register only.
REQ-008 Capture of align_a:
- Each rising edge with valid_a=1 and clr=0, align_a SHALL load data_a rotated left by sh.
- Otherwise align_a SHALL hold.
REQ-009 Capture of align_b:
- Each rising edge with valid_b=1 and clr=0, align_b SHALL load data_b rotated right by sh.
- Otherwise align_b SHALL hold.
REQ-010 Rotation SHALL be circular over 64 bits; sh=0 SHALL pass data unchanged.
REQ-011 On a rising edge with valid_a=1, valid_b=1 and clr=0:
- chk SHALL load chk + F, modulo 2^16.
- F = XOR of the four 16-bit words of (rotl(data_a,sh) XOR rotr(data_b,sh)).
- F SHALL use the values being captured that same edge.
REQ-012 On the same condition as REQ-011, cnt SHALL increment by 1, wrapping 255 -> 0.
REQ-013 When either valid is 0 (and clr=0), chk and cnt SHALL hold.
REQ-014 lzc SHALL equal the number of leading zeros of align_a, counting from bit 63:
- Range 0..64.
- 64 SHALL be reported when align_a is all zero.
REQ-015 clr=1 at a rising edge SHALL synchronously zero align_a, align_b, chk and cnt, overriding both valids.
REQ-016 Updates of align_a and align_b SHALL be independent; a single valid SHALL update only its own lane.
REQ-017 Latency SHALL be one cycle: inputs sampled at edge N are visible on out_flat after edge N.

Reset
REQ-018 On rst_n=0, align_a, align_b, chk and cnt SHALL clear to 0 immediately, independent of clk.
REQ-019 While reset is asserted, out_flat SHALL read 0 except lzc, which SHALL read 64 (0x40).
REQ-020 Reset asserted mid-operation SHALL discard all accumulated chk/cnt state.
REQ-021 The first capture after reset release SHALL occur on the first rising edge with rst_n=1.
REQ-022 No register SHALL take an X value after reset, regardless of in_flat content.

Verification
REQ-023 Lane A rotate: data_a=0x1, sh=4, valid_a=1, valid_b=0 -> align_a=0x10, lzc=59; align_b, chk and cnt unchanged.
REQ-024 Lane B rotate: data_b=0x1, sh=1, valid_b=1, valid_a=0 -> align_b=0x8000000000000000; align_a unchanged.
REQ-025 Checksum accumulation, from reset:
- data_a=0xFFFF, data_b=0, sh=0, both valid, for two edges -> chk=0xFFFF after the first edge, 0xFFFE after the second.
- cnt=2 after the second edge.
REQ-026 Cancelling operands: data_a=data_b=0x1, sh=0, both valid -> chk unchanged, cnt+1, align_a=align_b=0x1, lzc=63.
REQ-027 Clear and wrap:
- clr=1 with both valids set -> all fields 0, lzc=64.
- 256 both-valid edges after the clear -> cnt wraps back to 0.
REQ-028 Asynchronous reset: drop rst_n between clock edges after random traffic -> out_flat=0 except lzc=0x40 before the next edge.
REQ-029 Random regression: 200 cycles of random in_flat -> out_flat matches a cycle-accurate reference model of REQ-006..REQ-017 every cycle.
